// File: rtl/pipe_test_pkg.sv
// pipe_test_pkg: definitions shared by the pipe benchmark sources and checkers.
//   - pattern select codes (codes 4..7 behave as LFSR32)
//   - LFSR32 seed and tap mask (Fibonacci x^32+x^22+x^2+x+1, shifting left)
//   - pat_seed / pat_next: first word of a pattern and its successor
//   - rd_state_e: read-side FSM states of the pipe-out source
package pipe_test_pkg;

  localparam logic [2:0] PAT_LFSR  = 3'd0;
  localparam logic [2:0] PAT_COUNT = 3'd1;
  localparam logic [2:0] PAT_FIXED = 3'd2;
  localparam logic [2:0] PAT_WALK1 = 3'd3;

  localparam logic [31:0] LFSR_SEED = 32'h0D0C_0B0A;
  // Feedback taps at bit indices 31, 21, 1, 0 (polynomial terms 32, 22, 2, 1).
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ARMED,
    RD_BURST
  } rd_state_e;

  function automatic logic [31:0] pat_seed(input logic [2:0]  pat,
                                           input logic [31:0] fixed_word);
    case (pat)
      PAT_COUNT: return 32'd0;
      PAT_FIXED: return fixed_word;
      PAT_WALK1: return 32'd1;
      default:   return LFSR_SEED;
    endcase
  endfunction

  function automatic logic [31:0] pat_next(input logic [2:0]  pat,
                                           input logic [31:0] cur,
                                           input logic [31:0] fixed_word);
    case (pat)
      PAT_COUNT: return cur + 32'd1;
      PAT_FIXED: return fixed_word;
      PAT_WALK1: return {cur[30:0], cur[31]};
      default:   return {cur[30:0], ^(cur & LFSR_TAPS)};
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo32.sv
// sync_fifo32: single-clock 32-bit FIFO with occupancy count and registered
// read data.
//   clk, reset     : clock, asynchronous active-high reset
//   flush          : empties the FIFO (pointers and count to 0); rd_data is kept
//   wr_en, wr_data : push (ignored when full or flushing)
//   rd_en          : pop (ignored when empty or flushing)
//   rd_data        : word popped by the last successful read, held otherwise
//   count, full    : occupancy in words, full flag
module sync_fifo32 #(
  parameter int DEPTH = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [31:0]                wr_data,
  input  logic                       rd_en,
  output logic [31:0]                rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          wr_ok, rd_ok;

  always_comb begin
    wr_ok     = wr_en && (count_q != DEPTH_CNT) && !flush;
    rd_ok     = rd_en && (count_q != '0) && !flush;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        rd_data_d = mem[rd_ptr_q];
      end
      count_d = count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;
  assign full    = (count_q == DEPTH_CNT);

endmodule

// File: rtl/btpipe_out_source.sv
// btpipe_out_source: block-throttled test-pattern source for an okBTPipeOut
// endpoint (okClk domain). A throttle mask rotating right every cycle gates
// pattern writes into a FIFO; pipe_out_ready is raised only while a whole
// block is buffered and the endpoint has not yet started it.
//   clk, reset               : okClk, asynchronous active-high reset
//   pattern, fixed_pattern   : pattern select (sampled at reset release and on
//                              throttle_set) and the word for the FIXED pattern
//   throttle_set/_val        : reload throttle, reseed pattern, flush FIFO
//   pipe_out_read/_blockstrobe : endpoint strobes
//   pipe_out_data/_ready     : endpoint data (1-cycle read latency) and ready
//   block_count, underrun_count : statistics
// Build option: BTPIPE_SRC_STATS_EN implements the statistics counters;
// without it both counters read as 0.
module btpipe_out_source #(
  parameter int BLOCK_WORDS = 256,
  parameter int FIFO_DEPTH  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  pattern,
  input  logic [31:0] fixed_pattern,
  input  logic        throttle_set,
  input  logic [31:0] throttle_val,
  input  logic        pipe_out_read,
  input  logic        pipe_out_blockstrobe,
  output logic [31:0] pipe_out_data,
  output logic        pipe_out_ready,
  output logic [31:0] block_count,
  output logic [31:0] underrun_count
);

  import pipe_test_pkg::*;

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BAW = $clog2(BLOCK_WORDS);
  localparam logic [AW:0]    BLOCK_CNT = (AW+1)'(BLOCK_WORDS);
  localparam logic [BAW-1:0] LAST_BEAT = BAW'(BLOCK_WORDS - 1);

  logic [31:0]    thr_q, thr_d;
  logic [2:0]     pat_q, pat_d;
  logic [31:0]    word_q, word_d;
  logic           samp_q, samp_d;
  rd_state_e      state_q, state_d;
  logic [BAW-1:0] beat_q, beat_d;

  logic [2:0]  pat_eff;
  logic [31:0] cur_word;
  logic        gen_wr;
  logic [AW:0] fifo_count;
  logic        fifo_full;

  // Generator. samp_q marks the first cycle after reset: the pattern input is
  // used live and its seed stands in for the not-yet-sampled word register.
  always_comb begin
    pat_eff  = samp_q ? pattern : pat_q;
    cur_word = samp_q ? pat_seed(pattern, fixed_pattern) : word_q;
    if (pat_eff == PAT_FIXED) cur_word = fixed_pattern;
    gen_wr   = thr_q[0] && !fifo_full && !throttle_set;

    thr_d  = {thr_q[0], thr_q[31:1]};
    pat_d  = pat_eff;
    samp_d = 1'b0;
    word_d = gen_wr ? pat_next(pat_eff, cur_word, fixed_pattern) : cur_word;
    if (throttle_set) begin
      thr_d  = throttle_val;
      pat_d  = pattern;
      word_d = pat_seed(pattern, fixed_pattern);
    end
  end

  // Read FSM. Reads outside BURST still pop the FIFO but are not beats.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      RD_IDLE: begin
        if (fifo_count >= BLOCK_CNT) state_d = RD_ARMED;
      end
      RD_ARMED: begin
        if (pipe_out_blockstrobe) begin
          state_d = RD_BURST;
          beat_d  = '0;
        end
      end
      RD_BURST: begin
        if (pipe_out_read) begin
          if (beat_q == LAST_BEAT) state_d = RD_IDLE;
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = RD_IDLE;
    endcase
    if (throttle_set) begin
      state_d = RD_IDLE;
      beat_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr_q   <= '1;
      pat_q   <= PAT_LFSR;
      word_q  <= LFSR_SEED;
      samp_q  <= 1'b1;
      state_q <= RD_IDLE;
      beat_q  <= '0;
    end else begin
      thr_q   <= thr_d;
      pat_q   <= pat_d;
      word_q  <= word_d;
      samp_q  <= samp_d;
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  sync_fifo32 #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (throttle_set),
    .wr_en   (gen_wr),
    .wr_data (cur_word),
    .rd_en   (pipe_out_read),
    .rd_data (pipe_out_data),
    .count   (fifo_count),
    .full    (fifo_full)
  );

  assign pipe_out_ready = (state_q == RD_ARMED);

`ifdef BTPIPE_SRC_STATS_EN
  logic [31:0] blk_q, blk_d;
  logic [31:0] und_q, und_d;
  logic        blk_done, underrun;

  always_comb begin
    blk_done = (state_q == RD_BURST) && pipe_out_read && (beat_q == LAST_BEAT);
    underrun = pipe_out_read && (fifo_count == '0);
    blk_d    = blk_q + 32'(blk_done);
    und_d    = (underrun && (und_q != '1)) ? und_q + 32'd1 : und_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_q <= '0;
      und_q <= '0;
    end else begin
      blk_q <= blk_d;
      und_q <= und_d;
    end
  end

  assign block_count    = blk_q;
  assign underrun_count = und_q;
`else
  assign block_count    = '0;
  assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_btpipe_out_source.sv
// Bench for btpipe_out_source: a queue-based reference model (pattern stream,
// FIFO occupancy, throttle mask) tracks every clock edge; directed scenarios
// cover fill, LFSR stream, throttle, underrun, full FIFO and mid-burst reset,
// followed by randomized pattern/throttle/read traffic.
module tb_btpipe_out_source;

  localparam int BW    = 256;
  localparam int DEPTH = 1024;
`ifdef BTPIPE_SRC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  pattern = 3'd1;
  logic [31:0] fixed_pattern = 32'hA5A5_5A5A;
  logic        throttle_set = 1'b0;
  logic [31:0] throttle_val = 32'hFFFF_FFFF;
  logic        pipe_out_read = 1'b0;
  logic        pipe_out_blockstrobe = 1'b0;
  logic [31:0] pipe_out_data;
  logic        pipe_out_ready;
  logic [31:0] block_count;
  logic [31:0] underrun_count;

  always #5 clk = ~clk;

  btpipe_out_source #(
    .BLOCK_WORDS (BW),
    .FIFO_DEPTH  (DEPTH)
  ) u_dut (
    .clk                  (clk),
    .reset                (reset),
    .pattern              (pattern),
    .fixed_pattern        (fixed_pattern),
    .throttle_set         (throttle_set),
    .throttle_val         (throttle_val),
    .pipe_out_read        (pipe_out_read),
    .pipe_out_blockstrobe (pipe_out_blockstrobe),
    .pipe_out_data        (pipe_out_data),
    .pipe_out_ready       (pipe_out_ready),
    .block_count          (block_count),
    .underrun_count       (underrun_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_q[$];
  logic [31:0] m_thr;
  logic [31:0] m_word;
  logic [2:0]  m_pat;
  bit          m_samp;
  logic [31:0] m_data;
  logic [31:0] m_und;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_seed(input logic [2:0] pat);
    case (pat)
      3'd1:    return 32'd0;
      3'd2:    return fixed_pattern;
      3'd3:    return 32'd1;
      default: return 32'h0D0C_0B0A;
    endcase
  endfunction

  function automatic logic [31:0] ref_next(input logic [2:0] pat, input logic [31:0] w);
    case (pat)
      3'd1:    return w + 32'd1;
      3'd2:    return fixed_pattern;
      3'd3:    return {w[30:0], w[31]};
      default: return {w[30:0], w[31] ^ w[21] ^ w[1] ^ w[0]};
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_thr  = '1;
    m_samp = 1'b1;
    m_data = '0;
    m_und  = '0;
  endtask

  // One clock edge of the model, using the inputs the DUT sampled.
  task automatic model_edge(input bit rd, input bit set);
    int sz;
    if (m_samp) begin
      m_pat  = pattern;
      m_word = ref_seed(pattern);
      m_samp = 1'b0;
    end
    if (m_pat == 3'd2) m_word = fixed_pattern;
    if (set) begin
      m_q.delete();
      m_thr  = throttle_val;
      m_pat  = pattern;
      m_word = ref_seed(pattern);
    end else begin
      sz = m_q.size();
      if (rd) begin
        if (sz > 0) m_data = m_q.pop_front();
        else if (m_und != '1) m_und = m_und + 32'd1;
      end
      if (m_thr[0] && sz < DEPTH) begin
        m_q.push_back(m_word);
        m_word = ref_next(m_pat, m_word);
      end
      m_thr = {m_thr[0], m_thr[31:1]};
    end
  endtask

  task automatic tick(input bit rd, input bit bs);
    pipe_out_read        = rd;
    pipe_out_blockstrobe = bs;
    @(posedge clk);
    model_edge(rd, 1'b0);
    #1;
    pipe_out_read        = 1'b0;
    pipe_out_blockstrobe = 1'b0;
    check_eq("data", pipe_out_data, m_data);
  endtask

  task automatic tick_set(input logic [31:0] val, input logic [2:0] pat);
    pattern      = pat;
    throttle_val = val;
    throttle_set = 1'b1;
    @(posedge clk);
    model_edge(1'b0, 1'b1);
    #1;
    throttle_set = 1'b0;
    check_eq("set_data", pipe_out_data, m_data);
    check_eq("set_ready", 32'(pipe_out_ready), 32'd0);
  endtask

  // Outputs must clear as soon as reset rises, without waiting for an edge.
  task automatic do_reset(input logic [2:0] pat);
    pattern = pat;
    reset   = 1'b1;
    #1;
    check_eq("rst_data", pipe_out_data, 32'd0);
    check_eq("rst_ready", 32'(pipe_out_ready), 32'd0);
    check_eq("rst_blk", block_count, 32'd0);
    check_eq("rst_und", underrun_count, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Ready must rise exactly one edge after the model first holds a full block.
  task automatic wait_ready(input string tag, input int budget);
    int reach;
    int got;
    reach = (m_q.size() >= BW) ? 0 : -1;
    got   = -1;
    for (int i = 1; i <= budget; i++) begin
      tick(1'b0, 1'b0);
      if (reach < 0 && m_q.size() >= BW) reach = i;
      if (pipe_out_ready === 1'b1) begin
        got = i;
        break;
      end
    end
    if (got < 0) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    else         check_eq({tag, "_lat"}, 32'(got), 32'(reach + 1));
  endtask

  task automatic read_block(input string tag);
    tick(1'b0, 1'b1);
    check_eq({tag, "_rdy_drop"}, 32'(pipe_out_ready), 32'd0);
    for (int i = 0; i < BW; i++) tick(1'b1, 1'b0);
  endtask

  initial begin
    #2;
    // Reset and fill with COUNT
    do_reset(3'd1);
    for (int i = 0; i < BW; i++) tick(1'b0, 1'b0);
    check_eq("fill_early", 32'(pipe_out_ready), 32'd0);
    tick(1'b0, 1'b0);
    check_eq("fill_ready", 32'(pipe_out_ready), 32'd1);
    tick(1'b0, 1'b1);
    check_eq("fill_strobe", 32'(pipe_out_ready), 32'd0);
    tick(1'b1, 1'b0);
    check_eq("fill_first", pipe_out_data, 32'd0);
    for (int i = 1; i < BW; i++) tick(1'b1, 1'b0);
    check_eq("fill_last", pipe_out_data, 32'd255);
    check_eq("fill_blk", block_count, STATS ? 32'd1 : 32'd0);

    // LFSR stream over four blocks
    do_reset(3'd0);
    wait_ready("lfsr0", 400);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    check_eq("lfsr_first", pipe_out_data, 32'h0D0C_0B0A);
    for (int i = 1; i < BW; i++) tick(1'b1, 1'b0);
    for (int b = 1; b < 4; b++) begin
      wait_ready("lfsr_n", 400);
      read_block("lfsr_blk");
    end
    check_eq("lfsr_blk", block_count, STATS ? 32'd4 : 32'd0);

    // Throttle: one write every 32 cycles
    tick_set(32'h0000_0001, 3'd1);
    wait_ready("thr", 8400);
    read_block("thr");

    // Underrun with generator stopped
    do_reset(3'd1);
    tick_set(32'h0000_0000, 3'd1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    check_eq("und_cnt", underrun_count, STATS ? 32'd3 : 32'd0);
    check_eq("und_data", pipe_out_data, 32'd0);
    check_eq("und_ready", 32'(pipe_out_ready), 32'd0);

    // Full FIFO, then drain 1024 contiguous words
    do_reset(3'd1);
    for (int i = 0; i < 2000; i++) tick(1'b0, 1'b0);
    check_eq("full_ready", 32'(pipe_out_ready), 32'd1);
    tick(1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) tick(1'b1, 1'b0);
    check_eq("full_last", pipe_out_data, 32'd1023);

    // Reset in the middle of a burst
    do_reset(3'd0);
    wait_ready("mid0", 400);
    tick(1'b0, 1'b1);
    for (int i = 0; i < 100; i++) tick(1'b1, 1'b0);
    do_reset(3'd0);
    wait_ready("mid1", 400);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    check_eq("mid_seed", pipe_out_data, 32'h0D0C_0B0A);
    for (int i = 1; i < BW; i++) tick(1'b1, 1'b0);

    // Randomized patterns, throttles and read traffic
    for (int r = 0; r < 6; r++) begin
      logic [31:0] tv;
      fixed_pattern = $urandom;
      tv = $urandom;
      if (r == 0) tv = '1;
      tick_set(tv, 3'($urandom_range(0, 7)));
      for (int i = 0; i < 600; i++) begin
        if ((i % 150) == 0) fixed_pattern = $urandom;
        tick(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      end
      check_eq("rand_und", underrun_count, STATS ? m_und : 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btpipe_out_source.md
# btpipe_out_source

Block-throttled pipe-out data source for the pipe benchmark designs. It generates a selectable test pattern into an internal FIFO and presents it to an okBTPipeOut endpoint. `pipe_out_ready` asserts only when a full block is buffered. It is the transmit-side counterpart of the pipe-in checker: the host reads the stream and verifies it against the same pattern definitions. It sits between the okWireIn control wires and the okBTPipeOut endpoint, in the okClk domain.

## Interface
Parameters:
- `BLOCK_WORDS`, default 256: words per block transfer. Power of 2, ≥ 2.
- `FIFO_DEPTH`, default 1024: FIFO depth in 32-bit words. Power of 2, ≥ 2×`BLOCK_WORDS`.

Ports:
- `clk` in 1: okClk. One clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `pattern` in 3: pattern select, sampled only at reset release and on `throttle_set`.
- `fixed_pattern` in 32: word used by the FIXED pattern.
- `throttle_set` in 1: loads the throttle register from `throttle_val`.
- `throttle_val` in 32: throttle mask.
- `pipe_out_read` in 1: endpoint read strobe.
- `pipe_out_blockstrobe` in 1: endpoint block-start strobe.
- `pipe_out_data` out 32: data to the endpoint.
- `pipe_out_ready` out 1: a full block is available.
- `block_count` out 32: completed blocks (stats).
- `underrun_count` out 32: reads issued while the FIFO was empty (stats).

## Operation
- **Pattern codes:**
  - 0 = LFSR32, Fibonacci x^32+x^22+x^2+x+1, seed 32'h0D0C0B0A.
  - 1 = COUNT: starts at 0, +1 per word, wraps at 2^32.
  - 2 = FIXED: `fixed_pattern` on every word.
  - 3 = WALK1: 32'h1 rotated left 1 per word.
  - 4–7 = treated as LFSR32.
- **Generator:**
  - Throttle register rotates right by 1 every cycle.
  - A word is written to the FIFO when throttle bit 0 = 1 and the FIFO is not full.
  - The pattern advances only on a write.
- **Pattern reseed:** `throttle_set` reloads the throttle register, reseeds the pattern, flushes the FIFO and returns the FSM to IDLE.
- **Read FSM:**
  - IDLE → ARMED when fifo_count ≥ `BLOCK_WORDS`.
  - ARMED → BURST on `pipe_out_blockstrobe`.
  - BURST → IDLE after `BLOCK_WORDS` reads; `block_count` increments.
  - `pipe_out_ready` = 1 only in ARMED.
- **Reads:**
  - A read pops the FIFO and registers the popped word onto `pipe_out_data`.
  - A read with the FIFO empty increments `underrun_count` (saturating), and `pipe_out_data` holds its value.
  - Reads outside BURST are still honoured (pop/underrun rules apply) but do not advance the block counter.
- **Simultaneous events:**
  - Generator write and endpoint read in the same cycle: both occur, fifo_count is unchanged.
  - Write when full: suppressed, pattern not advanced.
  - `blockstrobe` in IDLE or BURST is ignored.
- **Reset values:**
  - `pipe_out_data` = 0; `pipe_out_ready` = 0; both counters = 0.
  - FIFO empty, FSM IDLE, throttle register all ones, pattern seeded.
- **Reset mid-burst:** immediate abort; all state returns to the reset values.

## Timing
- Read latency is 1: `pipe_out_data` is valid the cycle after `pipe_out_read` is sampled high.
- FIFO write-to-readable latency is 1 cycle.
- `pipe_out_ready` is registered: it asserts 1 cycle after fifo_count reaches `BLOCK_WORDS` and deasserts the cycle after `blockstrobe` is sampled.
- `throttle_set` takes effect on the next edge; the first new-pattern word is written no earlier than 1 cycle later.
- Peak throughput is 1 word/cycle with an all-ones throttle.

## Configuration
- `BTPIPE_SRC_STATS_EN` defined: `block_count` and `underrun_count` are implemented as described.
- Undefined:
  - Both counters are tied to 0 and their registers are removed.
  - The read and underrun behaviour is otherwise identical.

## Structure
- Shared package `pipe_test_pkg`:
  - Pattern code constants (PAT_LFSR, PAT_COUNT, PAT_FIXED, PAT_WALK1).
  - LFSR seed and tap constants.
  - A function computing the next pattern word.
- One sub-module, `sync_fifo32`: single-clock FIFO with depth `FIFO_DEPTH`, count output and registered read data.
- The FSM, generator and throttle logic live in the top level.

## Test plan
- **Reset and fill:** reset, pattern=1, throttle all ones → after 256+2 cycles `pipe_out_ready`=1; the first block read returns 0,1,…,255 with 1-cycle latency; `block_count`=1.
- **LFSR first word:** pattern=0 → first word read 32'h0D0C0B0A; subsequent words match a reference LFSR model for 4 blocks.
- **Throttle:** throttle_val=32'h0000_0001 → exactly 1 write per 32 cycles; `pipe_out_ready` asserts after 256×32 cycles (±2).
- **Underrun:** `BLOCK_WORDS`=4, throttle=0, issue 3 reads → `underrun_count`=3, `pipe_out_data` remains 0, `pipe_out_ready` stays 0.
- **Full FIFO:** no reads for 2000 cycles → fifo_count=1024; pattern=1 then reads return 0…1023 contiguously with no skip.
- **Mid-burst reset:** assert `reset` after 100 reads of a block → all outputs 0 within the same cycle; after release, the next block restarts the pattern from its seed.
